ir_packet_scheduler: RTL and testbench

Upstream companion to the IR transmitter state machine. It derives the IR carrier clock from the 100 MHz system clock and issues a one-carrier-period SEND_PACKET pulse at a fixed packet rate. It also presents a 4-bit COMMAND that is held stable for the whole packet. Its outputs drive the transmitter's CLK, SEND_PACKET and COMMAND inputs directly.

---
 rtl/ir_packet_scheduler.sv | 129 ++++++++++++
 tb/tb_ir_packet_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: derives the IR carrier from the system clock and launches
// one-carrier-period send pulses with a latched command. Optional stale-command timeout: IR_CMD_TIMEOUT_EN.
module ir_packet_scheduler #(
  parameter int CARRIER_HALF_PERIOD = 1389,
  parameter int HALF_WIDTH          = 11,
  parameter int PACKET_PERIOD       = 3600,
`ifdef IR_CMD_TIMEOUT_EN
  parameter int PACKET_WIDTH        = 12,
  parameter int TIMEOUT_PACKETS     = 10
`else
  parameter int PACKET_WIDTH        = 12
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [3:0] cmd_in_i,
  input  logic       cmd_valid_i,
  output logic       carrier_clk_o,
  output logic       send_packet_o,
  output logic [3:0] command_o,
  output logic       cmd_stale_o
);

  logic [HALF_WIDTH-1:0]   half_q, half_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic                    carrier_q, carrier_d;
  logic                    send_q, send_d;
  logic [3:0]              command_q, command_d;
  logic [3:0]              pending_q, pending_d;
  logic                    stale_q, stale_d;
  logic                    half_wrap_s, fall_s, pkt_wrap_s, launch_s;

`ifdef IR_CMD_TIMEOUT_EN
  localparam int STALE_WIDTH = $clog2(TIMEOUT_PACKETS + 1);
  logic [STALE_WIDTH-1:0] stale_cnt_q, stale_cnt_d;
`endif

  // A launch is the falling carrier toggle on which the packet counter wraps.
  always_comb begin
    half_wrap_s = (half_q == HALF_WIDTH'(CARRIER_HALF_PERIOD - 1));
    fall_s      = half_wrap_s & carrier_q;
    pkt_wrap_s  = (pkt_q == PACKET_WIDTH'(PACKET_PERIOD - 1));
    launch_s    = fall_s & pkt_wrap_s;
  end

  always_comb begin
    half_d    = half_wrap_s ? {HALF_WIDTH{1'b0}} : half_q + HALF_WIDTH'(1);
    carrier_d = half_wrap_s ? ~carrier_q : carrier_q;

    if (fall_s) begin
      pkt_d = pkt_wrap_s ? {PACKET_WIDTH{1'b0}} : pkt_q + PACKET_WIDTH'(1);
    end else begin
      pkt_d = pkt_q;
    end

    if (launch_s) begin
      send_d = enable_i;
    end else if (fall_s) begin
      send_d = 1'b0;
    end else begin
      send_d = send_q;
    end

    // Launch samples pending as it stood before this edge.
    command_d = (launch_s && enable_i) ? pending_q : command_q;
    pending_d = cmd_valid_i ? cmd_in_i : pending_q;
    stale_d   = 1'b0;

`ifdef IR_CMD_TIMEOUT_EN
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (cmd_valid_i) begin
      stale_cnt_d = {STALE_WIDTH{1'b0}};
      stale_d     = 1'b0;
    end else if (launch_s && enable_i) begin
      if (stale_cnt_q < STALE_WIDTH'(TIMEOUT_PACKETS)) begin
        stale_cnt_d = stale_cnt_q + STALE_WIDTH'(1);
      end else begin
        stale_cnt_d = stale_cnt_q;
      end
      if (stale_cnt_d == STALE_WIDTH'(TIMEOUT_PACKETS)) begin
        pending_d = 4'b0000;
        stale_d   = 1'b1;
      end else begin
        stale_d   = stale_q;
      end
    end else begin
      stale_cnt_d = stale_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q    <= {HALF_WIDTH{1'b0}};
      pkt_q     <= {PACKET_WIDTH{1'b0}};
      carrier_q <= 1'b0;
      send_q    <= 1'b0;
      command_q <= 4'b0000;
      pending_q <= 4'b0000;
      stale_q   <= 1'b0;
    end else begin
      half_q    <= half_d;
      pkt_q     <= pkt_d;
      carrier_q <= carrier_d;
      send_q    <= send_d;
      command_q <= command_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
    end
  end

`ifdef IR_CMD_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stale_cnt_q <= {STALE_WIDTH{1'b0}};
    end else begin
      stale_cnt_q <= stale_cnt_d;
    end
  end
`endif

  assign carrier_clk_o = carrier_q;
  assign send_packet_o = send_q;
  assign command_o     = command_q;
  assign cmd_stale_o   = stale_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Scoreboard bench for ir_packet_scheduler (H=4, P=10, timeout=3); honours IR_CMD_TIMEOUT_EN.
module tb_ir_packet_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] cmd_in;
  logic       cmd_valid;
  logic       carrier;
  logic       send;
  logic [3:0] command;
  logic       stale;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  logic send_prev = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
  } exp_t;
  exp_t sb_q[$];

`ifdef IR_CMD_TIMEOUT_EN
  localparam logic [3:0] TIMED_CMD_P1 = 4'b0000;
  localparam logic [3:0] TIMED_CMD_P3 = 4'b0000;
  localparam int         STALE_EXP    = 1;
`else
  localparam logic [3:0] TIMED_CMD_P1 = 4'b0101;
  localparam logic [3:0] TIMED_CMD_P3 = 4'b1000;
  localparam int         STALE_EXP    = 0;
`endif

  ir_packet_scheduler #(
    .CARRIER_HALF_PERIOD(4),
    .HALF_WIDTH(3),
    .PACKET_PERIOD(10),
`ifdef IR_CMD_TIMEOUT_EN
    .PACKET_WIDTH(4),
    .TIMEOUT_PACKETS(3)
`else
    .PACKET_WIDTH(4)
`endif
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .cmd_in_i(cmd_in),
    .cmd_valid_i(cmd_valid),
    .carrier_clk_o(carrier),
    .send_packet_o(send),
    .command_o(command),
    .cmd_stale_o(stale)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check_eq("wait_timeout", cyc, n);
  endtask

  task automatic drive_cmd(input int n, input logic [3:0] v);
    wait_cyc(n - 1);
    cmd_in    = v;
    cmd_valid = 1'b1;
    wait_cyc(n);
    cmd_valid = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.cmd = v;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: carrier phase every cycle, launches popped from the scoreboard, pulse width.
  always @(negedge clk) begin
    if (!rst_n) begin
      send_prev = 1'b0;
    end else begin
      check_eq("carrier", int'(carrier), (cyc / 4) % 2);
      if (send && !send_prev) begin
        check_eq("launch_expected", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("launch_cycle", cyc, e.cyc);
          check_eq("launch_command", int'(command), int'(e.cmd));
        end
        rise_cyc = cyc;
      end
      if (!send && send_prev) check_eq("pulse_width", cyc - rise_cyc, 8);
      send_prev = send;
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_in    = 4'b0000;
    #1;
    check_eq("rst_carrier", int'(carrier), 0);
    check_eq("rst_send", int'(send), 0);
    check_eq("rst_command", int'(command), 0);
    check_eq("rst_stale", int'(stale), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Phase 1: command load, disabled launch with coincident CMD_VALID, timeout run.
    push_exp(80, 4'b1010);
    drive_cmd(30, 4'b1010);
    wait_cyc(159);
    enable    = 1'b0;
    cmd_in    = 4'b0101;
    cmd_valid = 1'b1;
    push_exp(240, 4'b0101);
    wait_cyc(160);
    cmd_valid = 1'b0;
    enable    = 1'b1;
    check_eq("disabled_no_send", int'(send), 0);
    check_eq("disabled_cmd_hold", int'(command), 4'b1010);
    wait_cyc(200);
    check_eq("cmd_held_mid", int'(command), 4'b1010);
    push_exp(320, 4'b0101);
    push_exp(400, 4'b0101);
    push_exp(480, TIMED_CMD_P1);
    wait_cyc(399);
    check_eq("stale_before_p1", int'(stale), 0);
    wait_cyc(400);
    check_eq("stale_at_p1", int'(stale), STALE_EXP);
    wait_cyc(490);
    check_eq("sb_drain_p1", sb_q.size(), 0);

    // Phase 2: reset asserted in the middle of a pulse.
    do_reset();
    push_exp(80, 4'b1000);
    drive_cmd(20, 4'b1000);
    wait_cyc(84);
    check_eq("pre_rst_send", int'(send), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_send", int'(send), 0);
    check_eq("async_rst_carrier", int'(carrier), 0);
    check_eq("async_rst_command", int'(command), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Phase 3: single load then silence; timeout behaviour per build.
    push_exp(80, 4'b1000);
    push_exp(160, 4'b1000);
    push_exp(240, 4'b1000);
    push_exp(320, TIMED_CMD_P3);
    drive_cmd(20, 4'b1000);
    wait_cyc(239);
    check_eq("stale_before_p3", int'(stale), 0);
    wait_cyc(240);
    check_eq("stale_at_p3", int'(stale), STALE_EXP);
    wait_cyc(330);
    check_eq("sb_drain_p3", sb_q.size(), 0);
    check_eq("stale_hold_p3", int'(stale), STALE_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
